// File: rtl/dest_wave_collector.sv
// Collects LANES-wide ALU beats into a full wavefront buffer and hands the whole
// wavefront (VGPR data, SGPR/VCC bits, write mask) to the register-file write port.
//
// state | meaning
// FILL  | gathering beats, out_valid low, pass_cnt points at the next slot
// FULL  | complete wavefront presented, inputs stalled until out_ready
module dest_wave_collector #(
    parameter int LANES  = 16,
    parameter int PASSES = 4,
    parameter int DW     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*DW-1:0]             in_vgpr_data,
    input  logic [LANES-1:0]                in_sgpr_bits,
    input  logic [LANES-1:0]                in_vcc_bits,
    input  logic [LANES-1:0]                in_exec_bits,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*PASSES*DW-1:0]      out_vgpr_data,
    output logic [LANES*PASSES-1:0]         out_sgpr_data,
    output logic [LANES*PASSES-1:0]         out_vcc_value,
    output logic [LANES*PASSES-1:0]         out_wr_mask,
    output logic [$clog2(PASSES)-1:0]       pass_cnt
);

    localparam int PW = $clog2(PASSES);
    localparam logic [PW-1:0] LAST_SLOT = PW'(PASSES - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pass_next;
    logic            accept;
    logic            drain;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            pass_cnt <= '0;
        end else begin
            state    <= state_next;
            pass_cnt <= pass_next;
        end
    end

    // In FULL pass_cnt is always 0, so a beat accepted during drain never completes a wave.
    always_comb begin
        state_next = state;
        pass_next  = pass_cnt;
        if (clear) begin
            state_next = FILL;
            pass_next  = '0;
        end else begin
            if (drain) begin
                state_next = FILL;
            end
            if (accept) begin
                if (pass_cnt == LAST_SLOT) begin
                    pass_next  = '0;
                    state_next = FULL;
                end else begin
                    pass_next = pass_cnt + 1'b1;
                end
            end
        end
    end

    // Only the mask is cleared on drain/clear; data slots keep stale values until rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vgpr_data <= '0;
            out_sgpr_data <= '0;
            out_vcc_value <= '0;
            out_wr_mask   <= '0;
        end else if (clear) begin
            out_wr_mask <= '0;
        end else begin
            if (drain) begin
                out_wr_mask <= '0;
            end
            for (int s = 0; s < PASSES; s++) begin
                if (accept && (pass_cnt == PW'(s))) begin
                    out_vgpr_data[s*LANES*DW +: LANES*DW] <= in_vgpr_data;
                    out_sgpr_data[s*LANES +: LANES]       <= in_sgpr_bits;
                    out_vcc_value[s*LANES +: LANES]       <= in_vcc_bits;
                    out_wr_mask[s*LANES +: LANES]         <= in_exec_bits;
                end
            end
        end
    end

endmodule
